// File: rtl/toggle_rx_if.sv
// Event handshake bundle for toggle_rx: toggle line from the sender, the
// pending-event handshake to the consumer, and the counter/overrun status.
interface toggle_rx_if #(
  parameter int unsigned CNT_W = 8
);
  logic             tog_in;
  logic             evt_ready;
  logic             cnt_clr;
  logic             ovr_clr;
  logic             evt_valid;
  logic             ack_tog;
  logic [CNT_W-1:0] evt_cnt;
  logic             ovr;

  modport master (
    output tog_in, evt_ready, cnt_clr, ovr_clr,
    input  evt_valid, ack_tog, evt_cnt, ovr
  );

  modport slave (
    input  tog_in, evt_ready, cnt_clr, ovr_clr,
    output evt_valid, ack_tog, evt_cnt, ovr
  );
endinterface

// File: rtl/toggle_rx.sv
// Receives a toggle-encoded event line across clock domains, presents one
// pending event at a time, returns a toggle ack and counts every detected event.
module toggle_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  toggle_rx_if.slave  bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   tog_s;
  logic                   tog_d;
  logic                   edge_det;
  logic [0:0]             state;
  logic [0:0]             state_nxt;
  logic                   ack;
  logic                   ovr_q;
  logic [CNT_W-1:0]       cnt;
  logic                   consume;
  logic                   overrun;

  assign tog_s    = sync[SYNC_STAGES-1];
  assign edge_det = tog_s ^ tog_d;
  assign consume  = (state == PEND) && bus.evt_ready;
  assign overrun  = (state == PEND) && !bus.evt_ready && edge_det;

  // Chain and tog_d both reset to 0, so a line held high through reset
  // release is seen as one event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync  <= '0;
      tog_d <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], bus.tog_in};
      tog_d <= tog_s;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (edge_det) state_nxt = PEND;
      PEND:    if (bus.evt_ready && !edge_det) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ack   <= 1'b0;
      ovr_q <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (consume) ack <= ~ack;
      // Overrun set takes priority over a same-cycle clear.
      if (overrun) ovr_q <= 1'b1;
      else if (bus.ovr_clr) ovr_q <= 1'b0;
      if (bus.cnt_clr) cnt <= edge_det ? CNT_ONE : '0;
      else if (edge_det) cnt <= cnt + CNT_ONE;
    end
  end

  assign bus.evt_valid = (state == PEND);
  assign bus.ack_tog   = ack;
  assign bus.evt_cnt   = cnt;
  assign bus.ovr       = ovr_q;

endmodule
